// File: rtl/line_cmd_sequencer.sv
// Command feeder for the Bresenham line drawer: queues line commands, hands one
// line at a time to the drawer, and gates the drawer's pixel stream with pix_en.
module line_cmd_sequencer #(
  parameter int DEPTH       = 8,
  parameter int RESTART_CYC = 2,
  parameter int TIMEOUT     = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [10:0] cmd_x0,
  input  logic [10:0] cmd_y0,
  input  logic [10:0] cmd_x1,
  input  logic [10:0] cmd_y1,
  input  logic        cmd_chain,
  output logic [10:0] drw_x0,
  output logic [10:0] drw_y0,
  output logic [10:0] drw_x1,
  output logic [10:0] drw_y1,
  output logic        drw_restart,
  input  logic        drw_complete,
  output logic        pix_en,
  output logic        busy,
  output logic [15:0] lines_done,
  output logic        timeout_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RESTART_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_START  = 3'd2,
    S_WAIT   = 3'd3,
    S_FINISH = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [44:0]   mem_q [DEPTH];
  logic [44:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [44:0]   entry_q, entry_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          cmp_prev_q;
  logic [10:0]   chain_x_q, chain_x_d, chain_y_q, chain_y_d;
  logic [10:0]   drw_x0_q, drw_x0_d, drw_y0_q, drw_y0_d;
  logic [10:0]   drw_x1_q, drw_x1_d, drw_y1_q, drw_y1_d;
  logic          drw_restart_q, drw_restart_d;
  logic          pix_en_q, pix_en_d;
  logic          busy_q, busy_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic [15:0]   lines_done_q, lines_done_d;
  logic          timeout_err_q, timeout_err_d;

  logic push, pop, complete_rise;

  assign push          = cmd_valid && cmd_ready_q;
  assign pop           = (state_q == S_IDLE) && (count_q != '0);
  // A completion level already high when WAIT begins must not count.
  assign complete_rise = drw_complete && !cmp_prev_q;

  always_comb begin
    state_d       = state_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    entry_d       = entry_q;
    rcnt_d        = rcnt_q;
    tcnt_d        = tcnt_q;
    chain_x_d     = chain_x_q;
    chain_y_d     = chain_y_q;
    drw_x0_d      = drw_x0_q;
    drw_y0_d      = drw_y0_q;
    drw_x1_d      = drw_x1_q;
    drw_y1_d      = drw_y1_q;
    lines_done_d  = lines_done_q;
    timeout_err_d = timeout_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = {cmd_chain, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      entry_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        drw_x0_d = entry_q[44] ? chain_x_q : entry_q[43:33];
        drw_y0_d = entry_q[44] ? chain_y_q : entry_q[32:22];
        drw_x1_d = entry_q[21:11];
        drw_y1_d = entry_q[10:0];
        rcnt_d   = RW'(RESTART_CYC - 1);
        state_d  = S_START;
      end
      S_START: begin
        if (rcnt_q == '0) begin
          tcnt_d  = '0;
          state_d = S_WAIT;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      S_WAIT: begin
        if (complete_rise) begin
          state_d = S_FINISH;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = S_FINISH;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_FINISH: begin
        chain_x_d    = drw_x1_q;
        chain_y_d    = drw_y1_q;
        lines_done_d = lines_done_q + 16'd1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the next state.
    drw_restart_d = (state_d == S_START);
    pix_en_d      = (state_d == S_WAIT);
    busy_d        = (state_d != S_IDLE) || (count_d != '0);
    cmd_ready_d   = (count_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      entry_q       <= '0;
      rcnt_q        <= '0;
      tcnt_q        <= '0;
      cmp_prev_q    <= 1'b0;
      chain_x_q     <= '0;
      chain_y_q     <= '0;
      drw_x0_q      <= '0;
      drw_y0_q      <= '0;
      drw_x1_q      <= '0;
      drw_y1_q      <= '0;
      drw_restart_q <= 1'b0;
      pix_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b1;
      lines_done_q  <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      entry_q       <= entry_d;
      rcnt_q        <= rcnt_d;
      tcnt_q        <= tcnt_d;
      cmp_prev_q    <= drw_complete;
      chain_x_q     <= chain_x_d;
      chain_y_q     <= chain_y_d;
      drw_x0_q      <= drw_x0_d;
      drw_y0_q      <= drw_y0_d;
      drw_x1_q      <= drw_x1_d;
      drw_y1_q      <= drw_y1_d;
      drw_restart_q <= drw_restart_d;
      pix_en_q      <= pix_en_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
      lines_done_q  <= lines_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign drw_x0      = drw_x0_q;
  assign drw_y0      = drw_y0_q;
  assign drw_x1      = drw_x1_q;
  assign drw_y1      = drw_y1_q;
  assign drw_restart = drw_restart_q;
  assign pix_en      = pix_en_q;
  assign busy        = busy_q;
  assign lines_done  = lines_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Directed plus randomized bench for line_cmd_sequencer with a Bresenham drawer
// model and a command-queue reference model for endpoints and pixel counts.
module tb_line_cmd_sequencer;

  localparam int DEPTH = 8;
  localparam int RCYC  = 2;
  localparam int TMO   = 256;

  logic        clk = 1'b0;
  logic        reset, cmd_valid, cmd_ready, cmd_chain;
  logic [10:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic [10:0] drw_x0, drw_y0, drw_x1, drw_y1;
  logic        drw_restart, drw_complete, pix_en, busy, timeout_err;
  logic [15:0] lines_done;

  always #5 clk = ~clk;

  line_cmd_sequencer #(.DEPTH(DEPTH), .RESTART_CYC(RCYC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_chain(cmd_chain), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1),
    .drw_y1(drw_y1), .drw_restart(drw_restart), .drw_complete(drw_complete),
    .pix_en(pix_en), .busy(busy), .lines_done(lines_done), .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Drawer model: 0 = model's own completion flag, 1 = forced low, 2 = forced high.
  int   cmp_mode = 0;
  int   mx, my, merr, mdx, mdy, msx, msy, e2;
  bit   plotting = 1'b0, armed = 1'b0;
  logic m_cmp = 1'b0, pv_out = 1'b0;
  logic [10:0] px_out = 11'd0;

  assign drw_complete = (cmp_mode == 0) ? m_cmp : (cmp_mode == 2);

  always @(posedge clk) begin
    if (reset) begin
      plotting = 1'b0;
      armed    = 1'b0;
      m_cmp  <= 1'b0;
      pv_out <= 1'b0;
    end else if (drw_restart) begin
      mx = int'(drw_x0);
      my = int'(drw_y0);
      mdx = iabs(int'(drw_x1) - mx);
      mdy = -iabs(int'(drw_y1) - my);
      msx = (mx < int'(drw_x1)) ? 1 : -1;
      msy = (my < int'(drw_y1)) ? 1 : -1;
      merr = mdx + mdy;
      plotting = 1'b1;
      armed    = 1'b1;
      m_cmp  <= 1'b0;
      pv_out <= 1'b0;
    end else if (plotting) begin
      pv_out <= 1'b1;
      px_out <= 11'(mx);
      if (mx == int'(drw_x1) && my == int'(drw_y1)) begin
        plotting = 1'b0;
      end else begin
        e2 = 2 * merr;
        if (e2 >= mdy) begin merr += mdy; mx += msx; end
        if (e2 <= mdx) begin merr += mdx; my += msy; end
      end
    end else begin
      pv_out <= 1'b0;
      if (armed) m_cmp <= 1'b1;
    end
  end

  // Reference model: accepted commands in order, plus the last end point for chaining.
  typedef struct { bit ch; int x0; int y0; int x1; int y1; } cmd_t;
  cmd_t exp_q[$];
  cmd_t cur;
  int   last_x = 0, last_y = 0, ex0, ey0, pixcnt, exp_pix;
  bit   in_line = 1'b0, rec_x = 1'b0;
  bit   xset[int];
  logic [43:0] cur_ep;

  always @(negedge clk) begin
    if (reset) begin
      in_line = 1'b0;
    end else begin
      if (pix_en && !in_line) begin
        in_line = 1'b1;
        pixcnt  = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $error("FAIL line_unexpected: observed line start with no queued command, expected none");
        end else begin
          cur = exp_q.pop_front();
          ex0 = cur.ch ? last_x : cur.x0;
          ey0 = cur.ch ? last_y : cur.y0;
          last_x = cur.x1;
          last_y = cur.y1;
          cur_ep = {11'(ex0), 11'(ey0), 11'(cur.x1), 11'(cur.y1)};
          exp_pix = ((iabs(cur.x1 - ex0) > iabs(cur.y1 - ey0)) ?
                     iabs(cur.x1 - ex0) : iabs(cur.y1 - ey0)) + 1;
          check("line_endpoints", {drw_x0, drw_y0, drw_x1, drw_y1}, cur_ep);
        end
      end
      if (pix_en && in_line && pv_out) begin
        pixcnt++;
        if (rec_x) xset[int'(px_out)] = 1'b1;
      end
      if (!pix_en && in_line) begin
        in_line = 1'b0;
        check("line_pixels", pixcnt, exp_pix);
        check("line_ep_stable", {drw_x0, drw_y0, drw_x1, drw_y1}, cur_ep);
      end
    end
  end

  task automatic push(input bit ch, input int x0, input int y0, input int x1, input int y1);
    cmd_chain = ch;
    cmd_x0 = 11'(x0);
    cmd_y0 = 11'(y0);
    cmd_x1 = 11'(x1);
    cmd_y1 = 11'(y1);
    cmd_valid = 1'b1;
    for (int i = 0; i < 500 && !cmd_ready; i++) @(negedge clk);
    check("push_ready", cmd_ready, 1'b1);
    @(posedge clk);
    exp_q.push_back('{ch, x0, y0, x1, y1});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_pix(input logic lvl, input int budget, input string tag);
    for (int i = 0; i < budget && pix_en !== lvl; i++) @(negedge clk);
    check(tag, pix_en, lvl);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && busy !== 1'b0; i++) @(negedge clk);
    check(tag, busy, 1'b0);
  endtask

  int n;
  int base, rx0, ry0, rx1, ry1;
  bit rch;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_chain = 1'b0;
    cmd_x0 = 11'd0; cmd_y0 = 11'd0; cmd_x1 = 11'd0; cmd_y1 = 11'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pix_en", pix_en, 1'b0);
    check("rst_restart", drw_restart, 1'b0);
    check("rst_lines", lines_done, 16'd0);
    check("rst_tmo_err", timeout_err, 1'b0);
    check("rst_endpoints", {drw_x0, drw_y0, drw_x1, drw_y1}, 44'd0);
    reset = 1'b0;
    @(negedge clk);

    // Single line with latency profile and distinct-x count.
    rec_x = 1'b1;
    push(1'b0, 40, 200, 160, 0);
    @(negedge clk); check("lat_load_restart", drw_restart, 1'b0);
    check("lat_busy", busy, 1'b1);
    @(negedge clk); check("lat_start1_restart", drw_restart, 1'b1);
    check("lat_start1_pix", pix_en, 1'b0);
    @(negedge clk); check("lat_start2_restart", drw_restart, 1'b1);
    @(negedge clk); check("lat_wait_restart", drw_restart, 1'b0);
    check("lat_wait_pix", pix_en, 1'b1);
    wait_pix(1'b0, 400, "single_end");
    rec_x = 1'b0;
    wait_idle(20, "single_idle");
    check("single_lines", lines_done, 16'd1);
    check("single_distinct_x", xset.num(), 121);

    // Chained second line ignores its own start point.
    push(1'b0, 0, 0, 10, 5);
    push(1'b1, 7, 7, 20, 0);
    wait_idle(300, "chain_idle");
    check("chain_lines", lines_done, 16'd3);
    check("chain_start", {drw_x0, drw_y0}, {11'd10, 11'd5});
    check("chain_end", {drw_x1, drw_y1}, {11'd20, 11'd0});

    // FIFO full with the drawer stalled.
    cmp_mode = 1;
    for (int i = 0; i < 9; i++) push(1'b0, i, 2 * i, i + 4, 2 * i + 3);
    check("fifo_full_ready", cmd_ready, 1'b0);
    check("fifo_full_busy", busy, 1'b1);
    cmd_x0 = 11'd99; cmd_y0 = 11'd99; cmd_x1 = 11'd98; cmd_y1 = 11'd97;
    cmd_chain = 1'b0; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fifo_blocked_ready", cmd_ready, 1'b0);
    end
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    cmp_mode = 0;
    wait_pix(1'b0, 50, "fifo_l1_end");
    cmp_mode = 1;
    wait_pix(1'b1, 20, "fifo_l2_start");
    check("fifo_ready_after_pop", cmd_ready, 1'b1);
    repeat (20) @(negedge clk);
    cmp_mode = 0;
    wait_pix(1'b0, 50, "fifo_l2_end");
    cmp_mode = 1;
    @(negedge clk);
    push(1'b0, 50, 50, 53, 52);
    check("fifo_pushpop_ready", cmd_ready, 1'b1);
    push(1'b0, 60, 61, 62, 58);
    check("fifo_pushpop_full", cmd_ready, 1'b0);
    cmp_mode = 0;
    wait_idle(3000, "fifo_idle");
    check("fifo_lines", lines_done, 16'd14);
    check("fifo_no_tmo", timeout_err, 1'b0);

    // Timeout on a drawer that never completes, then the next line runs.
    cmp_mode = 1;
    push(1'b0, 100, 100, 103, 102);
    push(1'b0, 200, 50, 198, 55);
    wait_pix(1'b1, 20, "tmo_start");
    n = 0;
    while (pix_en && n < 2 * TMO) begin
      n++;
      @(negedge clk);
    end
    check("tmo_wait_cycles", n, TMO);
    check("tmo_err_set", timeout_err, 1'b1);
    cmp_mode = 0;
    wait_idle(400, "tmo_idle");
    check("tmo_lines", lines_done, 16'd16);
    check("tmo_err_sticky", timeout_err, 1'b1);

    // Completion level already high on WAIT entry is ignored.
    cmp_mode = 2;
    push(1'b0, 300, 300, 304, 301);
    wait_pix(1'b1, 20, "stale_start");
    repeat (30) @(negedge clk);
    check("stale_hold", pix_en, 1'b1);
    cmp_mode = 1;
    repeat (2) @(negedge clk);
    check("stale_low", pix_en, 1'b1);
    cmp_mode = 2;
    @(negedge clk);
    check("stale_rise", pix_en, 1'b0);
    cmp_mode = 0;
    wait_idle(20, "stale_idle");
    check("stale_lines", lines_done, 16'd17);

    // Reset in WAIT with three commands still queued.
    cmp_mode = 1;
    for (int i = 0; i < 4; i++) push(1'b0, 400 + i, 400, 405 + i, 404);
    wait_pix(1'b1, 20, "rst_mid_start");
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    last_x = 0;
    last_y = 0;
    @(negedge clk);
    check("rst_mid_pix", pix_en, 1'b0);
    check("rst_mid_restart", drw_restart, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ready", cmd_ready, 1'b1);
    check("rst_mid_lines", lines_done, 16'd0);
    check("rst_mid_tmo", timeout_err, 1'b0);
    reset = 1'b0;
    cmp_mode = 0;
    @(negedge clk);
    push(1'b1, 9, 9, 5, 3);
    wait_idle(100, "rst_chain_idle");
    check("rst_chain_start", {drw_x0, drw_y0}, {11'd0, 11'd0});
    check("rst_chain_lines", lines_done, 16'd1);

    // Randomized commands at both ends of the coordinate range.
    for (int ph = 0; ph < 2; ph++) begin
      base = ph * 2016;
      for (int k = 0; k < 12; k++) begin
        rch = (k == 0 || k == 5) ? 1'b0 : 1'($urandom_range(0, 1));
        rx0 = base + $urandom_range(0, 31);
        ry0 = base + $urandom_range(0, 31);
        rx1 = (k == 5) ? rx0 : base + $urandom_range(0, 31);
        ry1 = (k == 5) ? ry0 : base + $urandom_range(0, 31);
        push(rch, rx0, ry0, rx1, ry1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle(4000, "rand_idle");
    check("rand_lines", lines_done, 16'd25);
    check("rand_no_tmo", timeout_err, 1'b0);
    check("rand_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
